// File: rtl/snac_db15_pkg.sv
// Shared definitions for the SNAC DB15 controller responder: FSM state
// encoding, control bit map and the default serial frame length.
package snac_db15_pkg;

  // Two players of twelve controls each.
  localparam int PLAYER_BITS    = 12;
  localparam int FRAME_BITS_DEF = 2 * PLAYER_BITS;

  // Bit positions inside one player's control word (active-high on input).
  localparam int BIT_UP    = 0;
  localparam int BIT_DOWN  = 1;
  localparam int BIT_LEFT  = 2;
  localparam int BIT_RIGHT = 3;
  localparam int BIT_BTN1  = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOADED = 2'd1,
    ST_SHIFT  = 2'd2
  } state_t;

  // Wire-side frame: player 1 in the low half so P1 up leaves first, and
  // inverted because the host expects active-low buttons.
  function automatic logic [2*PLAYER_BITS-1:0] pack_frame(
    input logic [PLAYER_BITS-1:0] p1,
    input logic [PLAYER_BITS-1:0] p2
  );
    return ~{p2, p1};
  endfunction

endpackage

// File: rtl/db15_sync.sv
// N-stage synchronizer for one asynchronous host line, with a one-cycle
// pulse on the synchronized rising edge. All stages reset to 1 so an idle
// (pulled-up) host line produces no spurious edge after reset.
module db15_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic level,
  output logic rise
);

  logic [STAGES-1:0] chain;
  logic              level_d;

  // Shift the pin through the flop chain and keep one extra delayed copy
  // of the synchronized level for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain   <= '1;
      level_d <= 1'b1;
    end else begin
      chain[0] <= pin;
      for (int i = 1; i < STAGES; i++) begin
        chain[i] <= chain[i-1];
      end
      level_d <= chain[STAGES-1];
    end
  end

  assign level = chain[STAGES-1];
  assign rise  = level & ~level_d;

endmodule

// File: rtl/snac_db15_responder.sv
// SNAC DB15 responder: answers a host's load/clock serial poll with the
// two players' control states, LSB (P1 up) first, active-low on the wire.
// Optional build macro: DB15_TIMEOUT_EN adds an idle watchdog that drops a
// stalled LOADED/SHIFT transaction back to IDLE after TIMEOUT_CYC cycles.
//
// Host handshake: while the synchronized load line is low the register is
// reloaded every cycle and clock edges are ignored; each synchronized clock
// rising edge outside of load moves the next bit onto joy_data one cycle
// later. Load low always wins over a coincident clock edge.
module snac_db15_responder
  import snac_db15_pkg::*;
#(
  parameter int FRAME_BITS  = FRAME_BITS_DEF,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 48000
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        joy_load,
  input  logic        joy_clk,
  output logic        joy_data,
  input  logic [11:0] joy1_in,
  input  logic [11:0] joy2_in,
  output logic        frame_done,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  localparam int             CW       = $clog2(FRAME_BITS + 1);
  localparam logic [CW-1:0]  LAST_BIT = CW'(FRAME_BITS - 1);

  state_t                  state, state_next;
  logic [FRAME_BITS-1:0]   sr, sr_next;
  logic [CW-1:0]           cnt, cnt_next;
  logic                    done_next;
  logic                    load_level, load_rise;
  logic                    clk_level_unused, clk_rise;
  logic [2*PLAYER_BITS-1:0] raw_word;
  logic [FRAME_BITS-1:0]   load_word;
  logic                    to_hit;

  db15_sync #(.STAGES(SYNC_STAGES)) u_sync_load (
    .clk   (clk_sys),
    .rst_n (reset_n),
    .pin   (joy_load),
    .level (load_level),
    .rise  (load_rise)
  );

  db15_sync #(.STAGES(SYNC_STAGES)) u_sync_clk (
    .clk   (clk_sys),
    .rst_n (reset_n),
    .pin   (joy_clk),
    .level (clk_level_unused),
    .rise  (clk_rise)
  );

  assign raw_word = pack_frame(joy1_in, joy2_in);

  // Fit the 24-bit player word into the frame; any extra frame bits idle high.
  always_comb begin
    load_word = '1;
    for (int i = 0; i < FRAME_BITS && i < 2*PLAYER_BITS; i++) begin
      load_word[i] = raw_word[i];
    end
  end

`ifdef DB15_TIMEOUT_EN
  localparam int            TW      = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

  logic [TW-1:0] to_cnt;

  // Count cycles since the last host activity while a transaction is open.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      to_cnt <= '0;
    end else if (state == ST_IDLE || !load_level || load_rise || clk_rise) begin
      to_cnt <= '0;
    end else if (!to_hit) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  assign to_hit = (state != ST_IDLE) && (to_cnt == TO_LAST) && !clk_rise && !load_rise;
`else
  localparam int timeout_cyc_unused = TIMEOUT_CYC;
  assign to_hit = 1'b0;
`endif

  // Next-state, next shift register and frame-complete decision.
  always_comb begin
    state_next = state;
    sr_next    = sr;
    cnt_next   = cnt;
    done_next  = 1'b0;
    if (!load_level) begin
      state_next = ST_LOADED;
      sr_next    = load_word;
      cnt_next   = '0;
    end else if (state != ST_IDLE) begin
      if (to_hit) begin
        state_next = ST_IDLE;
        sr_next    = '1;
      end else begin
        if (state == ST_LOADED && load_rise) begin
          state_next = ST_SHIFT;
        end
        if (clk_rise) begin
          sr_next  = {1'b1, sr[FRAME_BITS-1:1]};
          cnt_next = cnt + 1'b1;
          if (cnt == LAST_BIT) begin
            state_next = ST_IDLE;
            sr_next    = '1;
            done_next  = 1'b1;
          end
        end
      end
    end
  end

  // State, shift register, bit counter and frame_done pulse registers.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      sr         <= '1;
      cnt        <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_next;
      sr         <= sr_next;
      cnt        <= cnt_next;
      frame_done <= done_next;
    end
  end

  assign joy_data  = sr[0];
  assign busy      = (state != ST_IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_snac_db15_responder.sv
// Directed bench for snac_db15_responder: table of player words with their
// hand-computed 24-bit wire frames, plus short sequences for latency, abort,
// coincident load/clock, input stability, idle watchdog and async reset.
module tb_snac_db15_responder;
  import snac_db15_pkg::*;

  localparam int FB = 24;

  logic        clk_sys  = 1'b0;
  logic        reset_n  = 1'b0;
  logic        joy_load = 1'b1;
  logic        joy_clk  = 1'b0;
  logic [11:0] joy1_in  = '0;
  logic [11:0] joy2_in  = '0;
  logic        joy_data;
  logic        frame_done;
  logic        busy;
  logic [1:0]  dbg_state;

  int pass_cnt  = 0;
  int check_cnt = 0;
  int fd_cnt    = 0;

  logic [FB-1:0] exp_q[$];

  typedef struct {
    logic [11:0]   p1;
    logic [11:0]   p2;
    logic [FB-1:0] word;
    string         name;
  } vec_t;

  vec_t vecs[5];

  snac_db15_responder dut (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .joy_load   (joy_load),
    .joy_clk    (joy_clk),
    .joy_data   (joy_data),
    .joy1_in    (joy1_in),
    .joy2_in    (joy2_in),
    .frame_done (frame_done),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  // Clock and frame_done pulse counter.
  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys) begin
    if (frame_done === 1'b1) fd_cnt++;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Host load pulse: hold low long enough to pass the synchronizer, then
  // release and wait until the release has been seen.
  task automatic do_load(input logic [11:0] p1, input logic [11:0] p2);
    joy1_in  = p1;
    joy2_in  = p2;
    joy_load = 1'b0;
    wait_cyc(4);
    joy_load = 1'b1;
    wait_cyc(3);
  endtask

  task automatic do_clk();
    joy_clk = 1'b1;
    wait_cyc(4);
    joy_clk = 1'b0;
    wait_cyc(4);
  endtask

  initial begin
    logic [FB-1:0] cap;
    logic [FB-1:0] exp_word;
    int            base;

    vecs[0] = '{12'h001, 12'h000, 24'hFFFFFE, "p1_up"};
    vecs[1] = '{12'hFFF, 12'h0A5, 24'hF5A000, "p1_all_p2_a5"};
    vecs[2] = '{12'h00F, 12'hF00, 24'h0FFFF0, "dirs_and_p2_btns"};
    vecs[3] = '{12'hA5A, 12'h5A5, 24'hA5A5A5, "alternating"};
    vecs[4] = '{12'h000, 12'h000, 24'hFFFFFF, "nothing_pressed"};

    // Reset values while reset is held.
    wait_cyc(3);
    check("rst_joy_data", joy_data, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_frame_done", frame_done, 1'b0);
    check("rst_state", dbg_state, ST_IDLE);
    reset_n = 1'b1;
    wait_cyc(2);

    // Table-driven full frames.
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(vecs[i].word);
      base = fd_cnt;
      do_load(vecs[i].p1, vecs[i].p2);
      check({vecs[i].name, "_busy_loaded"}, busy, 1'b1);
      cap[0] = joy_data;
      for (int k = 1; k < FB; k++) begin
        do_clk();
        cap[k] = joy_data;
      end
      check({vecs[i].name, "_no_early_done"}, fd_cnt - base, 0);
      do_clk();
      exp_word = exp_q.pop_front();
      check({vecs[i].name, "_frame"}, cap, exp_word);
      check({vecs[i].name, "_done_once"}, fd_cnt - base, 1);
      check({vecs[i].name, "_idle_busy"}, busy, 1'b0);
      do_clk();
      check({vecs[i].name, "_tail_ones"}, joy_data, 1'b1);
    end

    // New bit appears exactly one cycle after the synchronized edge.
    do_load(12'h002, 12'h000);
    check("lat_bit0", joy_data, 1'b1);
    joy_clk = 1'b1;
    wait_cyc(2);
    check("lat_before", joy_data, 1'b1);
    wait_cyc(1);
    check("lat_after", joy_data, 1'b0);
    joy_clk = 1'b0;
    wait_cyc(4);

    // Reload mid-frame restarts from bit 0 and completes one clean frame.
    base = fd_cnt;
    do_load(12'h001, 12'h000);
    for (int k = 0; k < 10; k++) do_clk();
    check("abort_bit10", joy_data, 1'b1);
    do_load(12'h001, 12'h000);
    check("abort_bit0_again", joy_data, 1'b0);
    check("abort_state", dbg_state, ST_SHIFT);
    for (int k = 0; k < FB - 1; k++) do_clk();
    check("abort_no_done_yet", fd_cnt - base, 0);
    do_clk();
    check("abort_done_once", fd_cnt - base, 1);
    check("abort_idle", busy, 1'b0);

    // Clock edge coincident with load low must not shift.
    joy1_in  = 12'h001;
    joy2_in  = 12'h000;
    joy_load = 1'b0;
    joy_clk  = 1'b1;
    wait_cyc(4);
    joy_clk  = 1'b0;
    joy_load = 1'b1;
    wait_cyc(3);
    check("coinc_bit0", joy_data, 1'b0);
    do_clk();
    check("coinc_bit1", joy_data, 1'b1);

    // Input changes after the load do not disturb the frame in flight.
    do_load(12'h001, 12'h000);
    joy1_in = 12'hFFE;
    joy2_in = 12'hFFF;
    wait_cyc(3);
    check("hold_bit0", joy_data, 1'b0);
    do_clk();
    check("hold_bit1", joy_data, 1'b1);
    do_clk();
    check("hold_bit2", joy_data, 1'b1);

    // Long idle in SHIFT: watchdog behaviour depends on the build.
    base = fd_cnt;
    do_load(12'hFFF, 12'h000);
    for (int k = 0; k < 5; k++) do_clk();
    check("idle_bit5", joy_data, 1'b0);
    wait_cyc(48010);
`ifdef DB15_TIMEOUT_EN
    check("idle_state", dbg_state, ST_IDLE);
    check("idle_busy", busy, 1'b0);
    check("idle_joy_data", joy_data, 1'b1);
`else
    check("idle_state", dbg_state, ST_SHIFT);
    check("idle_busy", busy, 1'b1);
    check("idle_joy_data", joy_data, 1'b0);
`endif
    check("idle_no_done", fd_cnt - base, 0);

    // Asynchronous reset mid-frame takes effect without a clock edge.
    do_load(12'hFFF, 12'h000);
    for (int k = 0; k < 7; k++) do_clk();
    check("pre_reset_bit7", joy_data, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_joy_data", joy_data, 1'b1);
    check("async_rst_busy", busy, 1'b0);
    check("async_rst_state", dbg_state, ST_IDLE);
    wait_cyc(2);
    reset_n = 1'b1;
    wait_cyc(2);
    check("post_rst_idle", busy, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
